// File: rtl/button_pkg.sv
// Shared constants and FSM state type for the push-button front end.
package button_pkg;

  localparam int NUM_BTN = 5;

  localparam int BTN_FWD  = 0;
  localparam int BTN_BACK = 1;
  localparam int BTN_JUMP = 2;
  localparam int BTN_ATK  = 3;
  localparam int BTN_DOWN = 4;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    ARM_HIGH = 2'd1,
    HIGH     = 2'd2,
    ARM_LOW  = 2'd3
  } btn_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchroniser, debounce FSM/counter, press/release pulses and
// a sticky event flag. BTN_AUTOREPEAT_EN adds repeat presses while held.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic ack,
  output logic level_o,
  output logic press_o,
  output logic rel_o,
  output logic evt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             evt_q, evt_d;
  logic             s;

`ifdef BTN_AUTOREPEAT_EN
  localparam int             REP_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REPEAT_DELAY - 1);
  // Reloading at DELAY-PERIOD makes later repeats land every PERIOD cycles.
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  assign s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      LOW: if (s) begin
        state_d = ARM_HIGH;
        cnt_d   = CNT_ONE;
      end
      ARM_HIGH: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: if (!s) begin
        state_d = ARM_LOW;
        cnt_d   = CNT_ONE;
      end
      ARM_LOW: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase
`ifdef BTN_AUTOREPEAT_EN
    rep_d = '0;
    if (state_q == HIGH && s) begin
      if (rep_q == REP_FIRE) begin
        press_d = 1'b1;
        rep_d   = REP_RELOAD;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
`endif
    level_d = (state_d == HIGH) || (state_d == ARM_LOW);
    // Set from the visible pulse so an ack in the same cycle loses.
    evt_d   = press_q | (evt_q & ~ack);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      evt_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      evt_q   <= evt_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;
  assign evt_o   = evt_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BTN independent debounce channels.
// Optional autorepeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int NUM_BTN         = button_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] evt_ack,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_evt
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw    (btn_raw[i]),
      .ack    (evt_ack[i]),
      .level_o(btn_level[i]),
      .press_o(btn_press[i]),
      .rel_o  (btn_release[i]),
      .evt_o  (btn_evt[i])
    );
  end

endmodule
